// File: rtl/alp_booth_mul_seq.sv
// Multi-cycle radix-2 Booth multiplier with a start/busy/done handshake.
// The accumulator is one bit wider than the operands, so the most negative value squared still fits.
module alp_booth_mul_seq #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic [W-1:0]     multiplicand,
    input  logic [W-1:0]     multiplier,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   product,
    output logic             err
);

    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EVAL  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]      state_r;
    logic [W:0]      a_r;
    logic [W:0]      m_r;
    logic [W-1:0]    q_r;
    logic            q_m1_r;
    logic [CW-1:0]   count_r;
    logic [2*W-1:0]  product_r;
    logic            busy_r;
    logic            done_r;
    logic            err_r;

    logic [W:0]      a_eval_s;
    logic [2*W+1:0]  chain_s;
    logic [2*W+1:0]  shifted_s;
    logic [W:0]      a_sh_s;
    logic [W-1:0]    q_sh_s;
    logic            q_m1_sh_s;
    logic [CW-1:0]   count_dec_s;

    // Booth add/subtract decision for the current bit pair.
    always_comb begin
        a_eval_s = a_r;
        case ({q_r[0], q_m1_r})
            2'b01:   a_eval_s = a_r + m_r;
            2'b10:   a_eval_s = a_r - m_r;
            default: a_eval_s = a_r;
        endcase
    end

    // Arithmetic right shift of the {A,Q,q_m1} chain and counter decrement.
    always_comb begin
        chain_s     = {a_r, q_r, q_m1_r};
        shifted_s   = {a_r[W], chain_s[2*W+1:1]};
        a_sh_s      = shifted_s[2*W+1:W+1];
        q_sh_s      = shifted_s[W:1];
        q_m1_sh_s   = shifted_s[0];
        count_dec_s = count_r - CW'(1);
    end

    // Sequencer state, datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            a_r       <= '0;
            m_r       <= '0;
            q_r       <= '0;
            q_m1_r    <= 1'b0;
            count_r   <= '0;
            product_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else if (clr) begin
            state_r   <= ST_IDLE;
            a_r       <= '0;
            m_r       <= '0;
            q_r       <= '0;
            q_m1_r    <= 1'b0;
            count_r   <= '0;
            product_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= '0;
                        q_r     <= multiplier;
                        q_m1_r  <= 1'b0;
                        m_r     <= {multiplicand[W-1], multiplicand};
                        count_r <= CW'(W);
                        busy_r  <= 1'b1;
                        state_r <= ST_EVAL;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_EVAL: begin
                    a_r     <= a_eval_s;
                    err_r   <= start;
                    state_r <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    a_r     <= a_sh_s;
                    q_r     <= q_sh_s;
                    q_m1_r  <= q_m1_sh_s;
                    count_r <= count_dec_s;
                    err_r   <= start;
                    // Product is captured from the final shifted chain as DONE is entered.
                    if (count_dec_s == CW'(0)) begin
                        product_r <= {a_sh_s[W-1:0], q_sh_s};
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        state_r   <= ST_EVAL;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;
    assign err     = err_r;

endmodule
